// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the execute stage (port 0) and the
// address/branch-target helper (port 1). A granted request is registered,
// held on the ALU for one EXEC cycle, and the captured result is returned
// to the granted port over a valid/ready response channel.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0
// wins every tie); by default ties are broken round-robin.
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*XLEN-1:0] i_req_op1,
  input  logic [NREQ*XLEN-1:0] i_req_op2,
  input  logic [NREQ*10-1:0]   i_req_ctrl,
  output logic [NREQ-1:0]      o_rsp_valid,
  input  logic [NREQ-1:0]      i_rsp_ready,
  output logic [XLEN-1:0]      o_rsp_res,
  output logic                 o_rsp_br,
  output logic [XLEN-1:0]      o_alu_op1,
  output logic [XLEN-1:0]      o_alu_op2,
  output logic [9:0]           o_alu_ctrl,
  input  logic [XLEN-1:0]      i_alu_res,
  input  logic                 i_alu_take_branch
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  logic [9:0]        r_ctrl;
  logic [XLEN-1:0]   r_res;
  logic              r_br;
  logic              r_gnt;
  logic              r_last;
  logic [NREQ-1:0]   r_rsp_valid;

  logic              w_winner;
  logic              w_any_valid;
  logic              w_rsp_hs;
  logic              w_accept;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic [9:0]        w_ctrl;

  // Winner selection among the currently valid requesters.
  always_comb begin
    w_winner    = 1'b0;
    w_any_valid = |i_req_valid;
    if (i_req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_winner = 1'b0;
`else
      w_winner = ~r_last;
`endif
    end else if (i_req_valid[1]) begin
      w_winner = 1'b1;
    end else begin
      w_winner = 1'b0;
    end
  end

  // Accept decision. In RESP a new request is taken back-to-back only when
  // the winner is the other port, so a port never sees req_ready and
  // rsp_valid together; a same-port follow-up is accepted from IDLE instead.
  always_comb begin
    w_rsp_hs = (r_state == ST_RESP) && i_rsp_ready[r_gnt];
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: w_accept = w_any_valid;
      ST_RESP: w_accept = w_rsp_hs && w_any_valid && (w_winner != r_gnt);
      default: w_accept = 1'b0;
    endcase
    if (!i_rst_n) begin
      w_accept = 1'b0;
    end else begin
      w_accept = w_accept;
    end
  end

  // Same-cycle ready to the winner and payload selection for the op register.
  always_comb begin
    o_req_ready    = 2'b00;
    o_req_ready[0] = w_accept & ~w_winner;
    o_req_ready[1] = w_accept & w_winner;
    if (w_winner) begin
      w_op1  = i_req_op1[XLEN +: XLEN];
      w_op2  = i_req_op2[XLEN +: XLEN];
      w_ctrl = i_req_ctrl[10 +: 10];
    end else begin
      w_op1  = i_req_op1[0 +: XLEN];
      w_op2  = i_req_op2[0 +: XLEN];
      w_ctrl = i_req_ctrl[0 +: 10];
    end
  end

  // Op register, grant and round-robin history, loaded only on accept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op1  <= {XLEN{1'b0}};
      r_op2  <= {XLEN{1'b0}};
      r_ctrl <= 10'd0;
      r_gnt  <= 1'b0;
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_op1  <= w_op1;
      r_op2  <= w_op2;
      r_ctrl <= w_ctrl;
      r_gnt  <= w_winner;
      r_last <= w_winner;
    end
  end

  // Control FSM: result capture in EXEC, response handshake in RESP.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_res       <= {XLEN{1'b0}};
      r_br        <= 1'b0;
      r_rsp_valid <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_res       <= i_alu_res;
          r_br        <= i_alu_take_branch;
          r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 2'b00;
            r_state     <= w_accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_alu_op1   = r_op1;
  assign o_alu_op2   = r_op2;
  assign o_alu_ctrl  = r_ctrl;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_res   = r_res;
  assign o_rsp_br    = r_br;

endmodule
